demux_stream: RTL and testbench

//  Parametrised, registered 1-to-N stream demultiplexer; next generation of the DEMUX1xx family.

---
 rtl/demux_stream.sv | 101 ++++++++++
 tb/tb_demux_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// Registered 1-to-N_CH stream demux with a 1-entry buffer per channel; optional DEMUX_DROP_CNT_EN drop counter.
// Latency: one cycle from accept to outValid; a drained-and-refilled channel sustains 1 word/cycle.
// Backpressure: outReady follows the target channel's free/draining state; out-of-range targets always accept.
module demux_stream #(
    parameter  int DATA_W = 4,
    parameter  int N_CH   = 8,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     inClk,
    input  logic                     inRst_n,
    input  logic [DATA_W-1:0]        inData,
    input  logic                     inValid,
    output logic                     outReady,
    input  logic [SEL_W-1:0]         inSel,
    input  logic                     inMode,
    output logic [N_CH*DATA_W-1:0]   outData,
    output logic [N_CH-1:0]          outValid,
    input  logic [N_CH-1:0]          inChReady,
    output logic [SEL_W-1:0]         outPtr
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]               outDropCnt
`endif
);

    logic [DATA_W-1:0] chData [N_CH];
    logic [N_CH-1:0]   chVld;
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   loadCh;
    logic [SEL_W-1:0]  tgt;
    logic [SEL_W-1:0]  ptr;
    logic              accept;

    assign tgt = inMode ? ptr : inSel;

    // hit stays all-zero for an out-of-range target, which is what makes it accept-and-drop.
    always_comb begin
        hit      = '0;
        outReady = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            hit[k] = (tgt == SEL_W'(k));
            if (hit[k]) begin
                outReady = ~chVld[k] | inChReady[k];
            end
        end
    end

    assign accept = inValid & outReady;
    assign loadCh = accept ? hit : '0;

    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            chVld <= '0;
            for (int k = 0; k < N_CH; k++) begin
                chData[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (loadCh[k]) begin
                    chVld[k]  <= 1'b1;
                    chData[k] <= inData;
                end else if (inChReady[k]) begin
                    chVld[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            ptr <= '0;
        end else if (accept && inMode) begin
            ptr <= (ptr == SEL_W'(N_CH - 1)) ? '0 : ptr + 1'b1;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] dropCnt;

    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            dropCnt <= '0;
        end else if (accept && (hit == '0) && (dropCnt != 8'hFF)) begin
            dropCnt <= dropCnt + 8'd1;
        end
    end

    assign outDropCnt = dropCnt;
`endif

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : gOut
            assign outData[g*DATA_W +: DATA_W] = chData[g];
        end
    endgenerate

    assign outValid = chVld;
    assign outPtr   = ptr;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: an 8-channel and a 6-channel instance checked against a per-channel buffer model.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  d8 = '0, d6 = '0;
    logic        v8 = 1'b0, v6 = 1'b0, mode8 = 1'b0, mode6 = 1'b0;
    logic [2:0]  sel8 = '0, sel6 = '0;
    logic [7:0]  cr8 = '0;
    logic [5:0]  cr6 = '0;
    logic        rdy8, rdy6;
    logic [31:0] od8;
    logic [23:0] od6;
    logic [7:0]  ov8;
    logic [5:0]  ov6;
    logic [2:0]  op8, op6;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]  drop8, drop6;
`endif

    demux_stream #(.DATA_W(4), .N_CH(8)) dut8 (
        .inClk(clk), .inRst_n(rst_n), .inData(d8), .inValid(v8), .outReady(rdy8),
        .inSel(sel8), .inMode(mode8), .outData(od8), .outValid(ov8),
        .inChReady(cr8), .outPtr(op8)
`ifdef DEMUX_DROP_CNT_EN
        , .outDropCnt(drop8)
`endif
    );

    demux_stream #(.DATA_W(4), .N_CH(6)) dut6 (
        .inClk(clk), .inRst_n(rst_n), .inData(d6), .inValid(v6), .outReady(rdy6),
        .inSel(sel6), .inMode(mode6), .outData(od6), .outValid(ov6),
        .inChReady(cr6), .outPtr(op6)
`ifdef DEMUX_DROP_CNT_EN
        , .outDropCnt(drop6)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is a one-word mailbox, the pointer a counter mod N.
    bit       mv8 [8];
    bit [3:0] md8 [8];
    int       mp8;
    bit       mv6 [6];
    bit [3:0] md6 [6];
    int       mp6;
    int       mdrop6;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin mv8[k] = 0; md8[k] = 0; end
        for (int k = 0; k < 6; k++) begin mv6[k] = 0; md6[k] = 0; end
        mp8 = 0; mp6 = 0; mdrop6 = 0;
    endtask

    function automatic int tgt8();
        return mode8 ? mp8 : int'(sel8);
    endfunction

    function automatic int tgt6();
        return mode6 ? mp6 : int'(sel6);
    endfunction

    function automatic bit exp_rdy8();
        int t = tgt8();
        if (t >= 8) return 1'b1;
        return !mv8[t] || cr8[t];
    endfunction

    function automatic bit exp_rdy6();
        int t = tgt6();
        if (t >= 6) return 1'b1;
        return !mv6[t] || cr6[t];
    endfunction

    function automatic logic [7:0] exp_v8();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = mv8[k];
        return r;
    endfunction

    function automatic logic [31:0] exp_d8();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[k*4 +: 4] = md8[k];
        return r;
    endfunction

    function automatic logic [5:0] exp_v6();
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = mv6[k];
        return r;
    endfunction

    function automatic logic [23:0] exp_d6();
        logic [23:0] r;
        for (int k = 0; k < 6; k++) r[k*4 +: 4] = md6[k];
        return r;
    endfunction

    // Apply the current inputs to the model, then move both DUTs one clock forward.
    task automatic advance();
        bit a8, a6;
        int t8, t6;
        t8 = tgt8(); a8 = v8 && exp_rdy8();
        t6 = tgt6(); a6 = v6 && exp_rdy6();
        for (int k = 0; k < 8; k++) if (cr8[k]) mv8[k] = 0;
        for (int k = 0; k < 6; k++) if (cr6[k]) mv6[k] = 0;
        if (a8 && t8 < 8) begin mv8[t8] = 1; md8[t8] = d8; end
        if (a6 && t6 < 6) begin mv6[t6] = 1; md6[t6] = d6; end
        if (a6 && t6 >= 6 && mdrop6 < 255) mdrop6++;
        if (a8 && mode8) mp8 = (mp8 + 1) % 8;
        if (a6 && mode6) mp6 = (mp6 + 1) % 6;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL reset_valid8 got %h exp 00", ov8); end
        checks++; if (od8 !== 32'h0) begin errors++; $display("FAIL reset_data8 got %h exp 0", od8); end
        checks++; if (op8 !== 3'd0) begin errors++; $display("FAIL reset_ptr8 got %0d exp 0", op8); end
        checks++; if (ov6 !== 6'h00 || od6 !== 24'h0) begin errors++; $display("FAIL reset_dut6 got v=%h d=%h exp 0/0", ov6, od6); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_explicit();
        cr8 = 8'hFF; mode8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v8 = 1'b1; sel8 = 3'(k); d8 = 4'(k + 1);
            #1;
            checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL explicit_ready ch%0d got %b exp 1", k, rdy8); end
            advance();
            checks++; if (ov8 !== (8'h01 << k)) begin errors++; $display("FAIL explicit_valid ch%0d got %h exp %h", k, ov8, 8'h01 << k); end
            checks++; if (od8[k*4 +: 4] !== 4'(k + 1)) begin errors++; $display("FAIL explicit_data ch%0d got %h exp %h", k, od8[k*4 +: 4], 4'(k + 1)); end
        end
        v8 = 1'b0;
        advance();
        checks++; if (ov8 !== 8'h00) begin errors++; $display("FAIL explicit_drain got %h exp 00", ov8); end
        checks++; if (od8 !== 32'h87654321) begin errors++; $display("FAIL explicit_hold got %h exp 87654321", od8); end
    endtask

    task automatic test_backpressure();
        cr8 = 8'hF7; mode8 = 1'b0; sel8 = 3'd3;
        v8 = 1'b1; d8 = 4'hA;
        advance();
        d8 = 4'hB;
        #1;
        checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b exp 0", rdy8); end
        advance();
        checks++; if (ov8[3] !== 1'b1 || od8[15:12] !== 4'hA) begin errors++; $display("FAIL bp_hold got v=%b d=%h exp 1/A", ov8[3], od8[15:12]); end
        cr8[3] = 1'b1;
        #1;
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", rdy8); end
        advance();
        checks++; if (ov8[3] !== 1'b1 || od8[15:12] !== 4'hB) begin errors++; $display("FAIL bp_reload got v=%b d=%h exp 1/B", ov8[3], od8[15:12]); end
        v8 = 1'b0;
        advance();
        checks++; if (ov8 !== exp_v8()) begin errors++; $display("FAIL bp_drain got %h exp %h", ov8, exp_v8()); end
    endtask

    task automatic test_roundrobin();
        cr8 = 8'hFF; mode8 = 1'b1; sel8 = 3'd5;
        for (int i = 0; i < 10; i++) begin
            v8 = 1'b1; d8 = 4'($urandom);
            advance();
            checks++; if (ov8 !== (8'h01 << (i % 8)) || od8[(i%8)*4 +: 4] !== d8) begin errors++; $display("FAIL rr_fill word%0d got v=%h d=%h exp v=%h d=%h", i, ov8, od8[(i%8)*4 +: 4], 8'h01 << (i % 8), d8); end
        end
        checks++; if (op8 !== 3'd2) begin errors++; $display("FAIL rr_ptr got %0d exp 2", op8); end
        cr8 = 8'hFD;
        for (int i = 0; i < 15; i++) begin
            d8 = 4'($urandom);
            advance();
        end
        checks++; if (op8 !== 3'd1 || ov8[1] !== 1'b1) begin errors++; $display("FAIL rr_at_full got ptr=%0d v1=%b exp 1/1", op8, ov8[1]); end
        #1;
        checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL rr_stall got %b exp 0", rdy8); end
        advance();
        checks++; if (op8 !== 3'd1) begin errors++; $display("FAIL rr_no_advance got %0d exp 1", op8); end
        cr8 = 8'hFF;
        #1;
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL rr_unstall got %b exp 1", rdy8); end
        advance();
        checks++; if (op8 !== 3'd2 || od8[7:4] !== d8) begin errors++; $display("FAIL rr_resume got ptr=%0d d=%h exp 2/%h", op8, od8[7:4], d8); end
        v8 = 1'b0; mode8 = 1'b0;
        advance();
    endtask

    task automatic test_reset_midstream();
        cr8 = 8'h00; mode8 = 1'b0; v8 = 1'b1;
        sel8 = 3'd2; d8 = 4'h7; advance();
        sel8 = 3'd5; d8 = 4'h9; advance();
        mode8 = 1'b1; cr8 = 8'h01; advance();
        v8 = 1'b0; mode8 = 1'b0;
        checks++; if (ov8[2] !== 1'b1 || ov8[5] !== 1'b1 || op8 === 3'd0) begin errors++; $display("FAIL mid_setup got v=%h ptr=%0d exp ch2,ch5 full ptr!=0", ov8, op8); end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (ov8 !== 8'h00 || od8 !== 32'h0 || op8 !== 3'd0) begin errors++; $display("FAIL mid_reset got v=%h d=%h p=%0d exp 0/0/0", ov8, od8, op8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cr8 = 8'hFF;
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        cr6 = 6'h00; mode6 = 1'b0; v6 = 1'b1;
        sel6 = 3'd2; d6 = 4'hC; advance();
        for (int i = 0; i < 3; i++) begin
            sel6 = (i == 1) ? 3'd7 : 3'd6; d6 = 4'($urandom);
            #1;
            checks++; if (rdy6 !== 1'b1) begin errors++; $display("FAIL oor_ready word%0d got %b exp 1", i, rdy6); end
            advance();
            checks++; if (ov6 !== 6'b000100 || od6 !== 24'h000C00) begin errors++; $display("FAIL oor_nochange word%0d got v=%h d=%h exp 04/000c00", i, ov6, od6); end
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++; if (drop6 !== 8'd3) begin errors++; $display("FAIL oor_cnt3 got %0d exp 3", drop6); end
`endif
        for (int i = 0; i < 300; i++) begin
            sel6 = 3'($urandom_range(6, 7));
            advance();
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++; if (drop6 !== 8'd255 || mdrop6 != 255) begin errors++; $display("FAIL oor_sat got %0d exp 255", drop6); end
`endif
        checks++; if (ov6 !== exp_v6()) begin errors++; $display("FAIL oor_final got %h exp %h", ov6, exp_v6()); end
        v6 = 1'b0; cr6 = 6'h3F;
        advance();
    endtask

    task automatic test_back_to_back();
        cr8 = 8'h10; mode8 = 1'b0; sel8 = 3'd4; v8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d8 = 4'($urandom);
            #1;
            checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc%0d got %b exp 1", i, rdy8); end
            advance();
            checks++; if (ov8[4] !== 1'b1 || od8[19:16] !== d8) begin errors++; $display("FAIL b2b_word cyc%0d got v=%b d=%h exp 1/%h", i, ov8[4], od8[19:16], d8); end
        end
        v8 = 1'b0;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            v8 = 1'($urandom); d8 = 4'($urandom); sel8 = 3'($urandom);
            mode8 = ($urandom_range(0, 3) == 0); cr8 = 8'($urandom);
            v6 = 1'($urandom); d6 = 4'($urandom); sel6 = 3'($urandom);
            mode6 = ($urandom_range(0, 3) == 0); cr6 = 6'($urandom);
            #1;
            checks++; if (rdy8 !== exp_rdy8() || rdy6 !== exp_rdy6()) begin errors++; $display("FAIL rnd_ready cyc%0d got %b/%b exp %b/%b", i, rdy8, rdy6, exp_rdy8(), exp_rdy6()); end
            advance();
            checks++; if (ov8 !== exp_v8() || od8 !== exp_d8() || op8 !== 3'(mp8)) begin errors++; $display("FAIL rnd_dut8 cyc%0d got v=%h d=%h p=%0d exp v=%h d=%h p=%0d", i, ov8, od8, op8, exp_v8(), exp_d8(), mp8); end
            checks++; if (ov6 !== exp_v6() || od6 !== exp_d6() || op6 !== 3'(mp6)) begin errors++; $display("FAIL rnd_dut6 cyc%0d got v=%h d=%h p=%0d exp v=%h d=%h p=%0d", i, ov6, od6, op6, exp_v6(), exp_d6(), mp6); end
`ifdef DEMUX_DROP_CNT_EN
            checks++; if (drop6 !== 8'(mdrop6)) begin errors++; $display("FAIL rnd_drop cyc%0d got %0d exp %0d", i, drop6, mdrop6); end
`endif
        end
        v8 = 1'b0; v6 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_explicit();
        test_backpressure();
        test_roundrobin();
        test_reset_midstream();
        test_out_of_range();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
